player_projectile: RTL and testbench

//  Player shot generator directly upstream of the vertical invader block. Spawns one

---
 rtl/player_projectile.sv | 133 +++++++++++++
 tb/tb_player_projectile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/player_projectile.sv
// Player shot generator: one projectile spawned at ship x, climbs per move tick, retires on hit or top.
// Optional PLAYER_PROJECTILE_AUTOFIRE_EN: spawn on fire level instead of rising edge.
module player_projectile #(
  parameter logic [9:0] SPAWN_Y        = 10'd440,
  parameter logic [9:0] TOP_Y          = 10'd0,
  parameter logic [9:0] SPEED          = 10'd4,
  parameter int         COOLDOWN_TICKS = 8
) (
  input  logic       dclk_i,
  input  logic       clr_i,
  input  logic       move_tick_i,
  input  logic       play_i,
  input  logic       fire_i,
  input  logic [9:0] ship_x_i,
  input  logic       hit_i,
  output logic [9:0] projectiles_x_o,
  output logic [9:0] projectiles_y_o,
  output logic       active_o,
  output logic [7:0] shots_fired_o,
  output logic [7:0] hits_o
);

  localparam logic [9:0] RETIRE_Y = TOP_Y + SPEED;
  localparam int CNT_W = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             fire_q, fire_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             active_q, active_d;
  logic [7:0]       shots_q, shots_d;
  logic [7:0]       hits_q, hits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

`ifdef PLAYER_PROJECTILE_AUTOFIRE_EN
  assign press = fire_i;
`else
  assign press = fire_i & ~fire_q;
`endif

  always_comb begin
    state_d  = state_q;
    fire_d   = fire_i;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    cnt_d    = cnt_q;
    if (!play_i) begin
      state_d  = IDLE;
      x_d      = '0;
      y_d      = '0;
      active_d = 1'b0;
      shots_d  = '0;
      hits_d   = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            state_d  = FLIGHT;
            x_d      = ship_x_i;
            y_d      = SPAWN_Y;
            active_d = 1'b1;
            if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
          end
        end
        FLIGHT: begin
          // A hit wins over a coincident top retirement so it is always counted.
          if (hit_i || (move_tick_i && (y_q <= RETIRE_Y))) begin
            state_d  = COOLDOWN;
            x_d      = '0;
            y_d      = '0;
            active_d = 1'b0;
            cnt_d    = CNT_LOAD;
            if (hit_i && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
          end else if (move_tick_i) begin
            y_d = y_q - SPEED;
          end
        end
        COOLDOWN: begin
          if (move_tick_i) begin
            if (cnt_q <= CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge dclk_i) begin
    if (clr_i) begin
      state_q  <= IDLE;
      fire_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      shots_q  <= '0;
      hits_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fire_q   <= fire_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      shots_q  <= shots_d;
      hits_q   <= hits_d;
      cnt_q    <= cnt_d;
    end
  end

  assign projectiles_x_o = x_q;
  assign projectiles_y_o = y_q;
  assign active_o        = active_q;
  assign shots_fired_o   = shots_q;
  assign hits_o          = hits_q;

endmodule

// File: tb/tb_player_projectile.sv
// Bench for player_projectile: directed scenarios plus random traffic against a behavioural model.
module tb_player_projectile;
  logic       clk = 1'b0;
  logic       clr, move_tick, play, fire, hit;
  logic [9:0] ship_x;
  logic [9:0] projectiles_x, projectiles_y;
  logic       active;
  logic [7:0] shots_fired, hits;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_x = 0, m_y = 0, m_shots = 0, m_hits = 0, m_cool = 0;
  bit m_fly = 0, m_fire_prev = 0;

  always #5 clk = ~clk;

  player_projectile dut (
    .dclk_i(clk), .clr_i(clr), .move_tick_i(move_tick), .play_i(play),
    .fire_i(fire), .ship_x_i(ship_x), .hit_i(hit),
    .projectiles_x_o(projectiles_x), .projectiles_y_o(projectiles_y),
    .active_o(active), .shots_fired_o(shots_fired), .hits_o(hits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic retire(input bit by_hit);
    m_fly = 0; m_x = 0; m_y = 0; m_cool = 8;
    if (by_hit && m_hits < 255) m_hits++;
  endtask

  task automatic model_step();
    bit press;
`ifdef PLAYER_PROJECTILE_AUTOFIRE_EN
    press = fire;
`else
    press = fire && !m_fire_prev;
`endif
    if (clr) begin
      m_fly = 0; m_x = 0; m_y = 0; m_shots = 0; m_hits = 0; m_cool = 0; m_fire_prev = 0;
    end else begin
      if (!play) begin
        m_fly = 0; m_x = 0; m_y = 0; m_shots = 0; m_hits = 0; m_cool = 0;
      end else if (m_fly) begin
        if (hit) retire(1);
        else if (move_tick) begin
          if (m_y <= 0 + 4) retire(0);
          else m_y = m_y - 4;
        end
      end else if (m_cool > 0) begin
        if (move_tick) m_cool--;
      end else if (press) begin
        m_fly = 1; m_x = ship_x; m_y = 440;
        if (m_shots < 255) m_shots++;
      end
      m_fire_prev = fire;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_x"}, projectiles_x, m_x);
    chk({tag, "_y"}, projectiles_y, m_y);
    chk({tag, "_active"}, active, m_fly);
    chk({tag, "_shots"}, shots_fired, m_shots);
    chk({tag, "_hits"}, hits, m_hits);
  endtask

  initial begin
    int guard;
    clr = 1; play = 0; fire = 0; move_tick = 0; hit = 0; ship_x = 0;

    // reset
    step("rst"); step("rst");
    chk("rst_active", active, 0);
    chk("rst_shots", shots_fired, 0);
    clr = 0;
    repeat (3) step("idle");
    chk("idle_active", active, 0);

    // spawn and climb
    play = 1; ship_x = 10'd200;
    step("pre_fire");
    fire = 1;
    step("spawn");
    chk("spawn_active", active, 1);
    chk("spawn_x", projectiles_x, 200);
    chk("spawn_y", projectiles_y, 440);
    chk("spawn_shots", shots_fired, 1);
    move_tick = 1;
    repeat (10) step("climb");
    move_tick = 0;
    chk("climb_y", projectiles_y, 400);
    chk("climb_x", projectiles_x, 200);

    // hit and cooldown gating
    fire = 0; hit = 1;
    step("hit");
    hit = 0;
    chk("hit_active", active, 0);
    chk("hit_y", projectiles_y, 0);
    chk("hit_count", hits, 1);
    ship_x = 10'd123;
    for (int i = 0; i < 8; i++) begin
      fire = 0; step("cd_gap");
      fire = 1; step("cd_edge");
      chk("cd_ignored", active, 0);
      fire = 0; move_tick = 1; step("cd_tick");
      move_tick = 0;
    end
    step("cd_done");
    fire = 1; step("respawn");
    chk("respawn_active", active, 1);
    chk("respawn_x", projectiles_x, 123);

    // run to the top without a hit
    move_tick = 1;
    guard = 0;
    while (projectiles_y != 10'd4 && guard < 200) begin step("top_run"); guard++; end
    chk("top_reach_y4", projectiles_y, 4);
    step("top_retire");
    chk("top_active", active, 0);
    chk("top_hits", hits, 1);
    repeat (8) step("top_cd");
    move_tick = 0; fire = 0;
    step("top_gap");
    fire = 1; step("spawn3");
    chk("spawn3_shots", shots_fired, 3);
    move_tick = 1;
    guard = 0;
    while (projectiles_y != 10'd4 && guard < 200) begin step("top_run2"); guard++; end
    chk("top2_reach_y4", projectiles_y, 4);
    hit = 1; step("top_hit");
    hit = 0;
    chk("top_hit_active", active, 0);
    chk("top_hit_hits", hits, 2);

    // play drop mid-flight
    repeat (8) step("cd3");
    move_tick = 0; fire = 0; step("gap4");
    fire = 1; step("spawn4");
    move_tick = 1;
    guard = 0;
    while (projectiles_y != 10'd300 && guard < 200) begin step("to300"); guard++; end
    chk("drop_y300", projectiles_y, 300);
    move_tick = 0; play = 0;
    step("drop");
    chk("drop_active", active, 0);
    chk("drop_x", projectiles_x, 0);
    chk("drop_y", projectiles_y, 0);
    chk("drop_shots", shots_fired, 0);
    chk("drop_hits", hits, 0);
    hit = 1; step("drop_hit");
    hit = 0;
    chk("drop_hit_ignored", hits, 0);

    // hold fire
    play = 1; fire = 0; step("hold_pre");
    fire = 1; move_tick = 1;
    repeat (200) step("hold");
`ifdef PLAYER_PROJECTILE_AUTOFIRE_EN
    chk("hold_shots", shots_fired, 2);
`else
    chk("hold_shots", shots_fired, 1);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 199) == 0);
      play = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      move_tick = ($urandom_range(0, 2) == 0);
      hit = ($urandom_range(0, 15) == 0);
      ship_x = 10'($urandom_range(0, 1023));
      step("rnd");
    end

    // counter saturation
    clr = 0; play = 0; step("sat_clr");
    play = 1; hit = 1; move_tick = 1;
    for (int i = 0; i < 4000; i++) begin
      fire = ~fire;
      step("sat");
    end
    chk("sat_shots", shots_fired, 255);
    chk("sat_hits", hits, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
